// File: rtl/relu_result_collector_pkg.sv
// Shared types and sizing helpers for the ReLU result collector.
package relu_result_collector_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_CELL_AMOUNT = 2;

    // Index width for n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_t;

endpackage

// File: rtl/relu_bank_ram.sv
// Two-bank register file: one write port for the fill side, one
// combinational read port for the drain side.
module relu_bank_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int CELL_AMOUNT = 2,
    parameter int IDX_W       = 1
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_bank,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2][CELL_AMOUNT];

    // NOTE: storage is deliberately not reset; a bank is only read after its
    // full flag is set, which requires every entry to have been written first.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/relu_result_collector.sv
// Captures ReLU output beats into a ping-pong buffer and replays each
// completed vector downstream over a valid/ready handshake.
module relu_result_collector
    import relu_result_collector_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int CELL_AMOUNT = DEFAULT_CELL_AMOUNT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] input_index,
    input  logic [DATA_WIDTH-1:0] input_value,
    input  logic                  input_enable,
    output logic [DATA_WIDTH-1:0] output_value,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic                  output_last,
    output logic                  overflow,
    output logic                  index_error
);

    localparam int               IDX_W    = idx_w(CELL_AMOUNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_AMOUNT - 1);

    logic [IDX_W-1:0]      wptr;
    logic                  fsel;
    logic [1:0]            full;
    logic                  fill_accept;
    logic                  fill_wrap;

    drain_state_t          state, state_d;
    logic [IDX_W-1:0]      rptr, rptr_d;
    logic                  dsel, dsel_d;
    logic                  fire;
    logic                  drain_done;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] value_d;
    logic                  last_d;

    assign fill_accept = input_enable && !full[fsel];
    assign fill_wrap   = fill_accept && (wptr == LAST_IDX);
    assign fire        = (state == SEND) && output_ready;
    assign drain_done  = fire && (rptr == LAST_IDX);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            fsel        <= 1'b0;
            overflow    <= 1'b0;
            index_error <= 1'b0;
        end else if (fill_accept) begin
            wptr <= fill_wrap ? '0 : wptr + 1'b1;
            if (fill_wrap) begin
                fsel <= ~fsel;
            end
            // The full index is compared, so stray upper bits are errors too.
            if (input_index != DATA_WIDTH'(wptr)) begin
                index_error <= 1'b1;
            end
        end else if (input_enable) begin
            overflow <= 1'b1;
        end
    end

    // Fill and drain always target different banks, so set and clear never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= '0;
        end else begin
            if (fill_wrap) begin
                full[fsel] <= 1'b1;
            end
            if (drain_done) begin
                full[dsel] <= 1'b0;
            end
        end
    end

    // NOTE: every signal is given a default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state;
        rptr_d  = rptr;
        dsel_d  = dsel;
        case (state)
            IDLE: begin
                if (full[dsel]) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (fire) begin
                    if (rptr == LAST_IDX) begin
                        rptr_d  = '0;
                        dsel_d  = ~dsel;
                        state_d = full[~dsel] ? SEND : IDLE;
                    end else begin
                        rptr_d = rptr + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        value_d = (state_d == SEND) ? rd_data : output_value;
        last_d  = (state_d == SEND) && (rptr_d == LAST_IDX);
    end

    // Output data is looked up at the next read address so it lands registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rptr         <= '0;
            dsel         <= 1'b0;
            output_value <= '0;
            output_last  <= 1'b0;
        end else begin
            state        <= state_d;
            rptr         <= rptr_d;
            dsel         <= dsel_d;
            output_value <= value_d;
            output_last  <= last_d;
        end
    end

    assign output_valid = (state == SEND);

    relu_bank_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .CELL_AMOUNT (CELL_AMOUNT),
        .IDX_W       (IDX_W)
    ) u_bank_ram (
        .clk     (clk),
        .wr_en   (fill_accept),
        .wr_bank (fsel),
        .wr_idx  (wptr),
        .wr_data (input_value),
        .rd_bank (dsel_d),
        .rd_idx  (rptr_d),
        .rd_data (rd_data)
    );

endmodule
